// File: rtl/uart_instr_loader.sv
// UART 8N1 receiver that pairs bytes into 16-bit instruction words, high byte first,
// and writes them to sequential instruction-memory addresses until halt, full or idle timeout.
module uart_instr_loader #(
    parameter int          CLKS_PER_BIT      = 868,
    parameter int          ADDR_W            = 8,
    parameter int          START_ADDR        = 1,
    parameter logic [15:0] HALT_WORD         = 16'hE000,
    parameter int          IDLE_TIMEOUT_BITS = 20
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rx,
    input  logic              i_clear,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [15:0]       o_mem_wdata,
    output logic              o_instr_transmit_done,
    output logic [ADDR_W-1:0] o_max_addr,
    output logic              o_frame_error,
    output logic              o_busy
);

    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int IDLE_W = $clog2(IDLE_TIMEOUT_BITS + 1);

    localparam logic [CNT_W-1:0]  HALF_LAST    = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  FULL_LAST    = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDLE_W-1:0] TIMEOUT_LAST = IDLE_W'(IDLE_TIMEOUT_BITS - 1);
    localparam logic [ADDR_W-1:0] ADDR_FIRST   = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_BEFORE  = ADDR_W'(START_ADDR - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST    = {ADDR_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t state, state_next;

    logic              rx_meta, rx_sync;
    logic [CNT_W-1:0]  clk_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift_reg;
    logic [7:0]        hi_byte;
    logic              expect_hi;
    logic              written;
    logic [CNT_W-1:0]  idle_clk;
    logic [IDLE_W-1:0] idle_bits;

    logic cnt_clr, bit_tick, byte_ok, stop_bad;

    // Two-flop synchronizer; idles high so reset cannot look like a start bit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)        state <= S_IDLE;
        else if (i_clear) state <= S_IDLE;
        else              state <= state_next;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_next = state;
        cnt_clr    = 1'b0;
        bit_tick   = 1'b0;
        byte_ok    = 1'b0;
        stop_bad   = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rx_sync) begin
                    state_next = S_START;
                    cnt_clr    = 1'b1;
                end
            end
            S_START: begin
                if (clk_cnt == HALF_LAST) begin
                    cnt_clr    = 1'b1;
                    state_next = rx_sync ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (clk_cnt == FULL_LAST) begin
                    cnt_clr  = 1'b1;
                    bit_tick = 1'b1;
                    if (bit_idx == 3'd7) state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (clk_cnt == FULL_LAST) begin
                    cnt_clr = 1'b1;
                    if (rx_sync) begin
                        byte_ok    = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        stop_bad   = 1'b1;
                        state_next = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (rx_sync) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign o_busy = (state != S_IDLE) && (state != S_WAIT_HIGH);

    // Bit timing and shift register need no clear: they are reloaded on every start bit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            clk_cnt   <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            clk_cnt <= cnt_clr ? '0 : clk_cnt + 1'b1;
            if (state == S_IDLE) bit_idx <= '0;
            else if (bit_tick)   bit_idx <= bit_idx + 1'b1;
            if (bit_tick) shift_reg <= {rx_sync, shift_reg[7:1]};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_mem_we              <= 1'b0;
            o_mem_addr            <= ADDR_FIRST;
            o_mem_wdata           <= '0;
            o_instr_transmit_done <= 1'b0;
            o_max_addr            <= ADDR_BEFORE;
            o_frame_error         <= 1'b0;
            hi_byte               <= '0;
            expect_hi             <= 1'b1;
            written               <= 1'b0;
            idle_clk              <= '0;
            idle_bits             <= '0;
        end else begin
            o_mem_we      <= 1'b0;
            o_frame_error <= 1'b0;
            if (i_clear) begin
                o_mem_addr            <= ADDR_FIRST;
                o_instr_transmit_done <= 1'b0;
                o_max_addr            <= ADDR_BEFORE;
                expect_hi             <= 1'b1;
                written               <= 1'b0;
                idle_clk              <= '0;
                idle_bits             <= '0;
            end else begin
                o_frame_error <= stop_bad && !o_instr_transmit_done;

                if (byte_ok && !o_instr_transmit_done) begin
                    if (expect_hi) begin
                        hi_byte   <= shift_reg;
                        expect_hi <= 1'b0;
                    end else begin
                        o_mem_we    <= 1'b1;
                        o_mem_wdata <= {hi_byte, shift_reg};
                        o_max_addr  <= o_mem_addr;
                        expect_hi   <= 1'b1;
                        written     <= 1'b1;
                    end
                end

                // Post-write bookkeeping; a full memory stops the address rather than wrapping.
                if (o_mem_we) begin
                    if (o_mem_wdata == HALT_WORD || o_mem_addr == ADDR_LAST)
                        o_instr_transmit_done <= 1'b1;
                    if (o_mem_addr != ADDR_LAST)
                        o_mem_addr <= o_mem_addr + 1'b1;
                end

                if (state != S_IDLE || !written || o_instr_transmit_done || !rx_sync) begin
                    idle_clk  <= '0;
                    idle_bits <= '0;
                end else if (idle_clk == FULL_LAST) begin
                    idle_clk <= '0;
                    if (idle_bits == TIMEOUT_LAST) begin
                        o_instr_transmit_done <= 1'b1;
                        expect_hi             <= 1'b1;
                        idle_bits             <= '0;
                    end else begin
                        idle_bits <= idle_bits + 1'b1;
                    end
                end else begin
                    idle_clk <= idle_clk + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_instr_loader.sv
// Self-checking bench for uart_instr_loader: serial stimulus, write scoreboard,
// framing, glitch, timeout, clear and reset scenarios at 16 clocks per bit.
module tb_uart_instr_loader;

    localparam int CPB    = 16;
    localparam int ADDR_W = 8;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rx = 1'b1;
    logic              clear = 1'b0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              done;
    logic [ADDR_W-1:0] max_addr;
    logic              frame_error;
    logic              busy;

    int n_compared   = 0;
    int n_mismatched = 0;

    wr_t exp_q[$];
    int  we_count = 0;
    int  fe_count = 0;
    int  busy_cycles = 0;
    logic prev_we = 1'b0;
    logic done_at_we = 1'b0;
    logic done_after_we = 1'b0;

    logic [7:0]  prog_bytes [22] = '{8'h41, 8'h26, 8'h81, 8'h80, 8'h41, 8'hC6, 8'h20, 8'h80,
                                     8'h91, 8'h30, 8'h51, 8'hC0, 8'h81, 8'h40, 8'hD0, 8'h40,
                                     8'h61, 8'hD0, 8'hC1, 8'h80, 8'hE0, 8'h00};
    logic [15:0] prog_words [11] = '{16'h4126, 16'h8180, 16'h41C6, 16'h2080, 16'h9130, 16'h51C0,
                                     16'h8140, 16'hD040, 16'h61D0, 16'hC180, 16'hE000};

    uart_instr_loader #(
        .CLKS_PER_BIT      (CPB),
        .ADDR_W            (ADDR_W),
        .START_ADDR        (1),
        .HALT_WORD         (16'hE000),
        .IDLE_TIMEOUT_BITS (20)
    ) dut (
        .i_clk                 (clk),
        .i_rst                 (rst),
        .i_rx                  (rx),
        .i_clear               (clear),
        .o_mem_we              (mem_we),
        .o_mem_addr            (mem_addr),
        .o_mem_wdata           (mem_wdata),
        .o_instr_transmit_done (done),
        .o_max_addr            (max_addr),
        .o_frame_error         (frame_error),
        .o_busy                (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard and event monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_we) done_after_we = done;
            if (mem_we) begin
                we_count++;
                done_at_we = done;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {8'h0, mem_addr, mem_wdata}, 32'h0);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(mem_addr), 32'(e.addr));
                    check("wr_data", 32'(mem_wdata), 32'(e.data));
                    check("wr_max_addr", 32'(max_addr), 32'(e.addr));
                end
            end
            if (frame_error) fe_count++;
            if (busy) busy_cycles++;
            prev_we = mem_we;
        end
    end

    task automatic bit_period(input logic v);
        rx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_stop);
        bit_period(1'b0);
        for (int i = 0; i < 8; i++) bit_period(b[i]);
        bit_period(!bad_stop);
        rx = 1'b1;
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) bit_period(1'b1);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [15:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    int we0, fe0, busy0;
    int wait_cycles;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_we", 32'(mem_we), 32'h0);
        check("rst_addr", 32'(mem_addr), 32'h1);
        check("rst_wdata", 32'(mem_wdata), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_max_addr", 32'(max_addr), 32'h0);
        check("rst_frame_error", 32'(frame_error), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        idle_bits(1);

        // Single word
        we0 = we_count;
        push_exp(8'd1, 16'h4126);
        send_byte(8'h41, 1'b0);
        send_byte(8'h26, 1'b0);
        idle_bits(2);
        check("t1_we_count", 32'(we_count - we0), 32'd1);
        check("t1_max_addr", 32'(max_addr), 32'd1);
        check("t1_done_at_we", 32'(done_at_we), 32'h0);
        check("t1_done_after_we", 32'(done_after_we), 32'h0);
        check("t1_done", 32'(done), 32'h0);
        pulse_clear();
        idle_bits(1);

        // Full program ending in the halt word
        we0 = we_count;
        for (int i = 0; i < 11; i++) push_exp(ADDR_W'(i + 1), prog_words[i]);
        for (int i = 0; i < 22; i++) send_byte(prog_bytes[i], 1'b0);
        idle_bits(1);
        check("t2_we_count", 32'(we_count - we0), 32'd11);
        check("t2_done_at_last_we", 32'(done_at_we), 32'h0);
        check("t2_done_after_halt", 32'(done_after_we), 32'h1);
        check("t2_done", 32'(done), 32'h1);
        check("t2_max_addr", 32'(max_addr), 32'd11);
        check("t2_sb_empty", 32'(exp_q.size()), 32'd0);
        pulse_clear();
        check("t2_done_cleared", 32'(done), 32'h0);
        idle_bits(1);

        // Bad stop bit, then a good word
        we0 = we_count;
        fe0 = fe_count;
        send_byte(8'h41, 1'b1);
        idle_bits(2);
        check("t3_frame_errors", 32'(fe_count - fe0), 32'd1);
        check("t3_no_write", 32'(we_count - we0), 32'd0);
        push_exp(8'd1, 16'h4126);
        send_byte(8'h41, 1'b0);
        send_byte(8'h26, 1'b0);
        idle_bits(1);
        check("t3_we_count", 32'(we_count - we0), 32'd1);
        pulse_clear();
        idle_bits(1);

        // Short low glitch
        we0 = we_count;
        fe0 = fe_count;
        busy0 = busy_cycles;
        rx = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rx = 1'b1;
        idle_bits(2);
        check("t4_busy_bounded", 32'((busy_cycles - busy0) >= 1 && (busy_cycles - busy0) <= CPB / 2 + 3), 32'h1);
        check("t4_no_error", 32'(fe_count - fe0), 32'd0);
        check("t4_no_write", 32'(we_count - we0), 32'd0);
        check("t4_busy_idle", 32'(busy), 32'h0);
        push_exp(8'd1, 16'h4126);
        send_byte(8'h41, 1'b0);
        send_byte(8'h26, 1'b0);
        idle_bits(1);
        check("t4_we_after_glitch", 32'(we_count - we0), 32'd1);
        pulse_clear();
        idle_bits(1);

        // Idle timeout with a dangling high byte
        we0 = we_count;
        push_exp(8'd1, 16'h4100);
        send_byte(8'h41, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h81, 1'b0);
        idle_bits(18);
        check("t5_done_early", 32'(done), 32'h0);
        wait_cycles = 0;
        while (!done && wait_cycles < 8 * CPB) begin
            @(posedge clk);
            #1;
            wait_cycles++;
        end
        check("t5_timeout_done", 32'(done), 32'h1);
        check("t5_we_count", 32'(we_count - we0), 32'd1);
        check("t5_max_addr", 32'(max_addr), 32'd1);

        // Bytes after done are ignored; clear restarts the session
        we0 = we_count;
        fe0 = fe_count;
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h56, 1'b1);
        idle_bits(1);
        check("t6_ignored_writes", 32'(we_count - we0), 32'd0);
        check("t6_ignored_errors", 32'(fe_count - fe0), 32'd0);
        check("t6_done_held", 32'(done), 32'h1);
        pulse_clear();
        check("t6_done_cleared", 32'(done), 32'h0);
        check("t6_addr_cleared", 32'(mem_addr), 32'd1);
        idle_bits(1);
        push_exp(8'd1, 16'h4100);
        send_byte(8'h41, 1'b0);
        send_byte(8'h00, 1'b0);
        idle_bits(1);
        check("t6_we_count", 32'(we_count - we0), 32'd1);
        check("t6_addr_next", 32'(mem_addr), 32'd2);

        // Reset in the middle of a byte
        we0 = we_count;
        bit_period(1'b0);
        bit_period(1'b1);
        bit_period(1'b0);
        check("t7_busy_mid_byte", 32'(busy), 32'h1);
        rst = 1'b1;
        #1;
        check("t7_rst_we", 32'(mem_we), 32'h0);
        check("t7_rst_addr", 32'(mem_addr), 32'd1);
        check("t7_rst_wdata", 32'(mem_wdata), 32'h0);
        check("t7_rst_done", 32'(done), 32'h0);
        check("t7_rst_max_addr", 32'(max_addr), 32'h0);
        check("t7_rst_frame_error", 32'(frame_error), 32'h0);
        check("t7_rst_busy", 32'(busy), 32'h0);
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle_bits(2);
        check("t7_no_write", 32'(we_count - we0), 32'd0);
        check("t7_busy_after", 32'(busy), 32'h0);
        check("sb_final_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
